// File: rtl/gf16_pkg.sv
// gf16_pkg: shared constants and types for the GF(2^4) datapath.
//   GF16_W       field element width (4)
//   GF16_POLY_LO low-order terms of the field polynomial x^4 + x + 1
//   gf16_state_t divider FSM state encoding
package gf16_pkg;

  localparam int unsigned GF16_W = 4;

  // x^4 == x + 1 in this field, so any x^4 term folds back as 4'b0011.
  localparam logic [GF16_W-1:0] GF16_POLY_LO = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    SQ,
    MUL,
    DONE
  } gf16_state_t;

endpackage

// File: rtl/gf16_divider_if.sv
// gf16_divider_if: operand / quotient handshake bundle for gf16_divider.
//   in_valid, a, b   operand side (producer -> divider)
//   in_ready         divider idle and able to accept operands
//   out_valid, q     quotient side (divider -> consumer)
//   out_ready        consumer accepts the quotient
//   dbz              divide-by-zero flag, present only with GF16_DIV_DBZ_EN
// modport master: the block driving operands and consuming results.
// modport slave : the divider itself.
interface gf16_divider_if;
  import gf16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [GF16_W-1:0] a;
  logic [GF16_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [GF16_W-1:0] q;

`ifdef GF16_DIV_DBZ_EN
  logic              dbz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dbz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dbz
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q
  );
`endif

endinterface

// File: rtl/gf16_mul_comb.sv
// gf16_mul_comb: purely combinational GF(2^4) multiplier, field x^4 + x + 1.
//   x, y  in   4  field operands
//   z     out  4  field product x * y
module gf16_mul_comb
  import gf16_pkg::*;
(
  input  logic [GF16_W-1:0] x,
  input  logic [GF16_W-1:0] y,
  output logic [GF16_W-1:0] z
);

  // Partial products: row gi is x gated by bit gi of y.
  logic [GF16_W-1:0] pp [GF16_W];

  genvar gi;
  generate
    for (gi = 0; gi < GF16_W; gi++) begin : g_pp
      assign pp[gi] = y[gi] ? x : '0;
    end
  endgenerate

  // Carry-less product S[6:0]: each row shifted into place and XOR-summed.
  logic [2*GF16_W-2:0] s;

  always_comb begin
    s = '0;
    for (int i = 0; i < GF16_W; i++) begin
      s = s ^ ({{(GF16_W-1){1'b0}}, pp[i]} << i);
    end
  end

  // Fold S4..S6 back with x^4 = x + 1:
  //   Z0 = S0^S4, Z1 = S1^S4^S5, Z2 = S2^S5^S6, Z3 = S3^S6
  assign z = s[GF16_W-1:0]
           ^ (s[4] ? GF16_POLY_LO         : '0)
           ^ (s[5] ? (GF16_POLY_LO << 1)  : '0)
           ^ (s[6] ? (GF16_POLY_LO << 2)  : '0);

endmodule

// File: rtl/gf16_divider.sv
// gf16_divider: sequential GF(2^4) divider, q = a * b^-1 with b^-1 = b^14.
// Square-and-multiply over three SQ/MUL rounds, sharing one multiplier:
//   acc = a * b^2 * b^4 * b^8 = a * b^14. b = 0 naturally yields q = 0.
// Ports:
//   clk    in  sole clock, rising edge
//   rst_n  in  asynchronous, active-low reset
//   bus    gf16_divider_if.slave: in_valid/in_ready/a/b operand handshake,
//          out_valid/out_ready/q result handshake, dbz when enabled
// Optional feature macro: GF16_DIV_DBZ_EN adds the registered dbz flag,
// capturing (b == 0) at accept and presenting it alongside q.
module gf16_divider
  import gf16_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  gf16_divider_if.slave  bus
);

  gf16_state_t       state_reg;
  logic [GF16_W-1:0] acc_reg;
  logic [GF16_W-1:0] sq_reg;
  logic [1:0]        iter_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [GF16_W-1:0] q_reg;

  // Shared multiplier: (sq, sq) while squaring, (acc, sq) while multiplying.
  logic [GF16_W-1:0] mul_x;
  logic [GF16_W-1:0] mul_z;

  assign mul_x = (state_reg == MUL) ? acc_reg : sq_reg;

  gf16_mul_comb u_mul (
    .x (mul_x),
    .y (sq_reg),
    .z (mul_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      sq_reg        <= '0;
      iter_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            acc_reg      <= bus.a;
            sq_reg       <= bus.b;
            iter_reg     <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= SQ;
          end
        end
        SQ: begin
          sq_reg    <= mul_z;
          state_reg <= MUL;
        end
        MUL: begin
          acc_reg <= mul_z;
          if (iter_reg == 2'd2) begin
            // Last round: the product goes straight into the output register.
            q_reg         <= mul_z;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            iter_reg  <= iter_reg + 2'd1;
            state_reg <= SQ;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.q         = q_reg;

`ifdef GF16_DIV_DBZ_EN
  logic dbz_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_reg <= 1'b0;
    end else if (state_reg == IDLE && bus.in_valid) begin
      dbz_reg <= (bus.b == '0);
    end
  end

  assign bus.dbz = dbz_reg;
`endif

endmodule
